// File: rtl/ili9341_pkg.sv
// ili9341_pkg: ILI9341 command codes, panel geometry and init ROM entry format.
package ili9341_pkg;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam int LCD_W  = 240;
    localparam int LCD_H  = 320;
    localparam int ROM_AW = 4;
    typedef enum logic [1:0] {
        ROM_CMD   = 2'b00,
        ROM_DATA  = 2'b01,
        ROM_DELAY = 2'b10,
        ROM_END   = 2'b11
    } rom_type_e;
    typedef struct packed {
        rom_type_e  typ;
        logic [7:0] payload;
    } rom_entry_t;
    function automatic rom_entry_t rom_entry(input rom_type_e t, input logic [7:0] p);
        rom_entry_t e;
        e.typ     = t;
        e.payload = p;
        return e;
    endfunction
endpackage

// File: rtl/spi_types.sv
// spi_types: transfer modes shared between the sequencer and spi_controller.
package spi_types;
    typedef enum logic [1:0] {
        WRITE_8  = 2'd0,
        WRITE_16 = 2'd1,
        READ_8   = 2'd2,
        READ_16  = 2'd3
    } spi_transaction_t;
endpackage

// File: rtl/ili9341_init_rom.sv
// ili9341_init_rom: combinational init script lookup.
//   addr_i  : script entry index
//   entry_o : {type, payload}; addresses past the script read as END
module ili9341_init_rom
    import ili9341_pkg::*;
(
    input  logic [ROM_AW-1:0] addr_i,
    output rom_entry_t        entry_o
);
    always_comb begin
        case (addr_i)
            4'd0:    entry_o = rom_entry(ROM_CMD,   CMD_SWRESET);
            4'd1:    entry_o = rom_entry(ROM_DELAY, 8'd5);
            4'd2:    entry_o = rom_entry(ROM_CMD,   CMD_SLPOUT);
            4'd3:    entry_o = rom_entry(ROM_DELAY, 8'd120);
            4'd4:    entry_o = rom_entry(ROM_CMD,   CMD_COLMOD);
            4'd5:    entry_o = rom_entry(ROM_DATA,  8'h55);
            4'd6:    entry_o = rom_entry(ROM_CMD,   CMD_MADCTL);
            4'd7:    entry_o = rom_entry(ROM_DATA,  8'h48);
            4'd8:    entry_o = rom_entry(ROM_CMD,   CMD_DISPON);
            default: entry_o = rom_entry(ROM_END,   8'h00);
        endcase
    end
endmodule

// File: rtl/ili9341_sequencer.sv
// ili9341_sequencer: panel reset, init script playback and per-pixel
// CASET/PASET/RAMWR sequencing in front of spi_controller.
//   clk, rst (async, active low)
//   spi_mode/spi_data/spi_valid -> spi_controller, spi_ready <- spi_controller
//   dc, lcd_rst_n               -> panel
//   init_done                   : init script finished (sticky)
//   px_valid/px_ready, px_x, px_y, px_color : plot request handshake
module ili9341_sequencer
    import ili9341_pkg::*;
    import spi_types::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int MS_CYCLES = CLK_HZ / 1000,
    parameter int RST_MS    = 10,
    parameter int WAKE_MS   = 120
) (
    input  logic             clk,
    input  logic             rst,
    output spi_transaction_t spi_mode,
    output logic [15:0]      spi_data,
    output logic             spi_valid,
    input  logic             spi_ready,
    output logic             dc,
    output logic             lcd_rst_n,
    output logic             init_done,
    input  logic             px_valid,
    output logic             px_ready,
    input  logic [8:0]       px_x,
    input  logic [8:0]       px_y,
    input  logic [15:0]      px_color
);
    localparam int HOLD_MS = RST_MS > WAKE_MS ? RST_MS : WAKE_MS;
    localparam int MAX_MS  = HOLD_MS > 255 ? HOLD_MS : 255;
    localparam int CW      = $clog2(MAX_MS * MS_CYCLES + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t RST_CYC  = cnt_t'(RST_MS * MS_CYCLES);
    localparam cnt_t WAKE_CYC = cnt_t'(WAKE_MS * MS_CYCLES);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_RST_WAIT, S_INIT_FETCH, S_INIT_ISSUE, S_DELAY, S_IDLE, S_PLOT
    } state_e;
    // Per-transfer handshake: load fields, raise valid a cycle later, hold
    // until accepted, then follow spi_ready low and back high.
    typedef enum logic [2:0] {P_LOAD, P_RAISE, P_HOLD, P_LO, P_HI} phase_e;

    state_e           state_q;
    phase_e           ph_q;
    logic [ROM_AW-1:0] ptr_q;
    logic [2:0]       step_q;
    cnt_t             cnt_q;
    logic [8:0]       x_q, y_q;
    logic [15:0]      col_q;
    logic             spi_valid_q, dc_q, lcd_rst_n_q, init_done_q, px_ready_q;
    logic [15:0]      spi_data_q;
    spi_transaction_t spi_mode_q;

    rom_entry_t       entry;
    cnt_t             lim;
    logic             tick, in_range, cmd_step, nx_dc;
    logic [15:0]      nx_data;
    spi_transaction_t nx_mode;

    ili9341_init_rom u_rom (
        .addr_i  (ptr_q),
        .entry_o (entry)
    );

    assign lim      = state_q == S_RST_HOLD ? RST_CYC :
                      state_q == S_RST_WAIT ? WAKE_CYC :
                      cnt_t'(entry.payload) * cnt_t'(MS_CYCLES);
    assign tick     = cnt_q + cnt_t'(1) >= lim;
    assign in_range = px_x < 9'(LCD_W) && px_y < 9'(LCD_H);
    // Plot steps 0, 3, 6 are the CASET/PASET/RAMWR command bytes.
    assign cmd_step = step_q == 3'd0 || step_q == 3'd3 || step_q == 3'd6;
    assign nx_dc    = state_q == S_PLOT ? !cmd_step : entry.typ == ROM_DATA;
    assign nx_mode  = state_q == S_PLOT && !cmd_step ? WRITE_16 : WRITE_8;
    assign nx_data  = state_q != S_PLOT ? {8'h00, entry.payload} :
                      step_q == 3'd0    ? {8'h00, CMD_CASET} :
                      step_q == 3'd3    ? {8'h00, CMD_PASET} :
                      step_q == 3'd6    ? {8'h00, CMD_RAMWR} :
                      step_q < 3'd3     ? {7'd0, x_q} :
                      step_q < 3'd6     ? {7'd0, y_q} : col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RST_HOLD;
            ph_q        <= P_LOAD;
            ptr_q       <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            spi_valid_q <= 1'b0;
            spi_data_q  <= '0;
            spi_mode_q  <= WRITE_8;
            dc_q        <= 1'b0;
            lcd_rst_n_q <= 1'b0;
            init_done_q <= 1'b0;
            px_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RST_HOLD, S_RST_WAIT, S_DELAY: begin
                    cnt_q <= tick ? '0 : cnt_q + cnt_t'(1);
                    if (tick) begin
                        lcd_rst_n_q <= 1'b1;
                        state_q     <= state_q == S_RST_HOLD ? S_RST_WAIT : S_INIT_FETCH;
                        if (state_q == S_DELAY) ptr_q <= ptr_q + ROM_AW'(1);
                    end
                end
                S_INIT_FETCH: begin
                    case (entry.typ)
                        ROM_DELAY: state_q <= S_DELAY;
                        ROM_END: begin
                            state_q     <= S_IDLE;
                            init_done_q <= 1'b1;
                            px_ready_q  <= 1'b1;
                        end
                        default: begin
                            state_q <= S_INIT_ISSUE;
                            ph_q    <= P_LOAD;
                        end
                    endcase
                end
                S_IDLE: begin
                    if (px_valid && px_ready_q) begin
                        px_ready_q <= 1'b0;
                        x_q        <= px_x;
                        y_q        <= px_y;
                        col_q      <= px_color;
                        if (in_range) begin
                            state_q <= S_PLOT;
                            step_q  <= '0;
                            ph_q    <= P_LOAD;
                        end
                    end else begin
                        px_ready_q <= 1'b1;
                    end
                end
                S_INIT_ISSUE, S_PLOT: begin
                    case (ph_q)
                        P_LOAD: if (spi_ready && !spi_valid_q) begin
                            dc_q       <= nx_dc;
                            spi_data_q <= nx_data;
                            spi_mode_q <= nx_mode;
                            ph_q       <= P_RAISE;
                        end
                        P_RAISE: begin
                            spi_valid_q <= 1'b1;
                            ph_q        <= P_HOLD;
                        end
                        P_HOLD: if (spi_ready) begin
                            spi_valid_q <= 1'b0;
                            ph_q        <= P_LO;
                        end
                        P_LO: if (!spi_ready) ph_q <= P_HI;
                        default: if (spi_ready) begin
                            ph_q <= P_LOAD;
                            if (state_q == S_INIT_ISSUE) begin
                                ptr_q   <= ptr_q + ROM_AW'(1);
                                state_q <= S_INIT_FETCH;
                            end else if (step_q == 3'd7) begin
                                state_q    <= S_IDLE;
                                px_ready_q <= 1'b1;
                            end else begin
                                step_q <= step_q + 3'd1;
                            end
                        end
                    endcase
                end
                default: state_q <= S_RST_HOLD;
            endcase
        end
    end

    assign spi_valid = spi_valid_q;
    assign spi_data  = spi_data_q;
    assign spi_mode  = spi_mode_q;
    assign dc        = dc_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign init_done = init_done_q;
    assign px_ready  = px_ready_q;
endmodule

// File: tb/tb_ili9341_sequencer.sv
// tb_ili9341_sequencer: checks reset/wake timing, init stream, plot streams and SPI handshake rules.
module tb_ili9341_sequencer;
    import spi_types::*;

    typedef struct packed {
        logic             dc;
        spi_transaction_t mode;
        logic [15:0]      data;
    } xfer_t;
    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
        bit          inr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    spi_transaction_t spi_mode;
    logic [15:0]      spi_data;
    logic             spi_valid, spi_ready, dc, lcd_rst_n, init_done, px_ready;
    logic             px_valid = 1'b0;
    logic [8:0]       px_x = '0, px_y = '0;
    logic [15:0]      px_color = '0;

    int    ncmp = 0, nerr = 0;
    int    cyc = 0, ntx = 0, busy = 0, busy_len = 3, last_end = 0, gap01 = 0, gap11 = 0;
    bit    rdy = 1'b1, stall = 1'b0, pv = 1'b0, acc;
    xfer_t prv, cur;
    logic [7:0] last_byte = '0;
    xfer_t exp_q[$];
    vec_t  vt[7];

    always #5 clk = ~clk;
    assign spi_ready = rdy & !stall;

    ili9341_sequencer #(.MS_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_mode  (spi_mode),
        .spi_data  (spi_data),
        .spi_valid (spi_valid),
        .spi_ready (spi_ready),
        .dc        (dc),
        .lcd_rst_n (lcd_rst_n),
        .init_done (init_done),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic d, input spi_transaction_t m, input logic [15:0] v);
        mk.dc   = d;
        mk.mode = m;
        mk.data = v;
    endfunction

    task automatic push_plot(input logic [8:0] x, input logic [8:0] y, input logic [15:0] c);
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h002A));
        exp_q.push_back(mk(1'b1, WRITE_16, {7'd0, x}));
        exp_q.push_back(mk(1'b1, WRITE_16, {7'd0, x}));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h002B));
        exp_q.push_back(mk(1'b1, WRITE_16, {7'd0, y}));
        exp_q.push_back(mk(1'b1, WRITE_16, {7'd0, y}));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h002C));
        exp_q.push_back(mk(1'b1, WRITE_16, c));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset();
        check("rst_spi_valid", spi_valid, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_spi_mode", spi_mode, WRITE_8);
        check("rst_dc", dc, 0);
        check("rst_lcd_rst_n", lcd_rst_n, 0);
        check("rst_init_done", init_done, 0);
        check("rst_px_ready", px_ready, 0);
    endtask

    // SPI slave model and protocol monitor, sampled 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            cur = mk(dc, spi_mode, spi_data);
            if (!rst) begin
                rdy       = 1'b1;
                busy      = 0;
                last_byte = '0;
            end else begin
                acc = pv && spi_ready;
                if (!(spi_ready && !pv)) check("issue_rule", cur, prv);
                if (spi_valid && !pv) begin
                    check("valid_after_fields", cur, prv);
                    if (last_byte == 8'h01) gap01 = cyc - last_end;
                    if (last_byte == 8'h11) gap11 = cyc - last_end;
                end
                if (pv && !acc) check("valid_hold", spi_valid, 1);
                if (acc) begin
                    check("valid_drop", spi_valid, 0);
                    ntx++;
                    if (exp_q.size() == 0) begin
                        ncmp++;
                        nerr++;
                        $display("FAIL xfer_unexpected: got 0x%0h, expected no transfer", prv);
                    end else begin
                        check("xfer", prv, exp_q.pop_front());
                    end
                    last_byte = prv.data[7:0];
                    rdy  = 1'b0;
                    busy = busy_len;
                end else if (!rdy) begin
                    if (busy > 1) busy--;
                    else begin
                        rdy      = 1'b1;
                        last_end = cyc;
                    end
                end
            end
            pv  = spi_valid;
            prv = cur;
        end
    end

    task automatic do_init();
        int  n;
        bit  pre_bad;
        rst = 1'b0;
        #1;
        check_reset();
        exp_q.delete();
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h0001));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h0011));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h003A));
        exp_q.push_back(mk(1'b1, WRITE_8, 16'h0055));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h0036));
        exp_q.push_back(mk(1'b1, WRITE_8, 16'h0048));
        exp_q.push_back(mk(1'b0, WRITE_8, 16'h0029));
        repeat (3) @(posedge clk);
        #2;
        ntx   = 0;
        gap01 = 0;
        gap11 = 0;
        rst   = 1'b1;
        n = 0;
        while (!lcd_rst_n && n < 100) begin step(); n++; end
        check("rst_low_cycles", n, 40);
        n = 0;
        while (!spi_valid && n < 1000) begin step(); n++; end
        check("wake_at_least_480", n >= 480, 1);
        check("wake_at_most_490", n <= 490, 1);
        px_x     = 9'd10;
        px_y     = 9'd10;
        px_valid = 1'b1;
        pre_bad  = 1'b0;
        n = 0;
        while (!init_done && n < 5000) begin
            if (px_ready) pre_bad = 1'b1;
            step();
            n++;
        end
        px_valid = 1'b0;
        check("init_done", init_done, 1);
        check("px_ready_before_init", pre_bad, 0);
        check("init_xfer_count", ntx, 7);
        check("init_exp_left", exp_q.size(), 0);
        check("init_last_done", rdy, 1);
        check("gap_after_01", gap01 >= 20, 1);
        check("gap_after_11", gap11 >= 480, 1);
        check("px_ready_after_init", px_ready, 1);
    endtask

    task automatic plot(input logic [8:0] x, input logic [8:0] y, input logic [15:0] c, input bit inr);
        int n, n0;
        n = 0;
        while (!px_ready && n < 100) begin step(); n++; end
        check("px_ready_wait", px_ready, 1);
        if (inr) push_plot(x, y, c);
        n0       = ntx;
        px_x     = x;
        px_y     = y;
        px_color = c;
        px_valid = 1'b1;
        step();
        px_valid = 1'b0;
        check("px_ready_drop", px_ready, 0);
        n = 0;
        if (inr) begin
            while (!spi_valid && n < 20) begin step(); n++; end
            check("first_valid_latency", n <= 2 && spi_valid, 1);
            n = 0;
            while (!(px_ready && exp_q.size() == 0) && n < 3000) begin step(); n++; end
            check("plot_px_ready_back", px_ready, 1);
            check("plot_exp_left", exp_q.size(), 0);
            check("plot_xfer_count", ntx - n0, 8);
        end else begin
            while (!px_ready && n < 20) begin step(); n++; end
            check("oor_ready_back", n <= 2 && px_ready, 1);
            step();
            check("oor_no_spi", ntx - n0, 0);
            check("oor_no_valid", spi_valid, 0);
        end
    endtask

    initial begin
        int n, base;
        logic [8:0] rx, ry;
        vt[0] = '{9'd5,   9'd300, 16'hF800, 1'b1};
        vt[1] = '{9'd0,   9'd0,   16'h0000, 1'b1};
        vt[2] = '{9'd239, 9'd319, 16'hFFFF, 1'b1};
        vt[3] = '{9'd240, 9'd0,   16'h1234, 1'b0};
        vt[4] = '{9'd0,   9'd320, 16'h0001, 1'b0};
        vt[5] = '{9'd511, 9'd511, 16'hAAAA, 1'b0};
        vt[6] = '{9'd100, 9'd200, 16'h07E0, 1'b1};
        #7;
        do_init();
        for (int i = 0; i < 7; i++) plot(vt[i].x, vt[i].y, vt[i].c, vt[i].inr);
        for (int i = 0; i < 25; i++) begin
            busy_len = $urandom_range(1, 6);
            rx = 9'($urandom_range(0, 300));
            ry = 9'($urandom_range(0, 400));
            plot(rx, ry, 16'($urandom), rx < 9'd240 && ry < 9'd320);
        end
        busy_len = 12;
        push_plot(9'd33, 9'd44, 16'hBEEF);
        px_x     = 9'd33;
        px_y     = 9'd44;
        px_color = 16'hBEEF;
        px_valid = 1'b1;
        step();
        px_valid = 1'b0;
        n = 0;
        while (!spi_valid && n < 20) begin step(); n++; end
        stall = 1'b1;
        repeat (10) step();
        check("stall_valid_held", spi_valid, 1);
        check("stall_data_held", spi_data, 16'h002A);
        check("stall_dc_held", dc, 0);
        stall = 1'b0;
        n = 0;
        while (!(px_ready && exp_q.size() == 0) && n < 3000) begin step(); n++; end
        check("stall_plot_done", exp_q.size(), 0);
        busy_len = 3;
        push_plot(9'd7, 9'd123, 16'h1234);
        base     = ntx;
        px_x     = 9'd7;
        px_y     = 9'd123;
        px_color = 16'h1234;
        px_valid = 1'b1;
        step();
        px_valid = 1'b0;
        n = 0;
        while (!(ntx == base + 4 && spi_valid) && n < 2000) begin step(); n++; end
        check("midop_step5_offered", spi_valid && ntx == base + 4, 1);
        check("midop_step5_data", spi_data, 16'd123);
        do_init();
        plot(9'd5, 9'd300, 16'hF800, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ili9341_sequencer.md
# ili9341_sequencer

Upstream command/pixel sequencer for `spi_controller` in the Etch-a-sketch display path. After reset it pulses the panel reset line, then plays a fixed ILI9341 init script (commands, parameters, millisecond delays) from a small ROM. It then accepts single-pixel plot requests and emits the CASET / PASET / RAMWR transaction sequence for each. It drives the panel D/C line and keeps it consistent with every SPI transfer it issues.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000, system clock frequency.
- `MS_CYCLES`, CLK_HZ/1000, clock cycles per delay unit. Benches shrink this.
- `RST_MS`, 10, panel reset low time, in delay units.
- `WAKE_MS`, 120, wait after panel reset release, in delay units.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `spi_mode` out `spi_transaction_t`: mode for the offered transfer.
- `spi_data` out 16: payload. 8-bit modes use [7:0]; [15:8] = 0.
- `spi_valid` out 1: transfer offered.
- `spi_ready` in 1: `spi_controller` `i_ready`. It is low from the cycle after acceptance until the transfer ends.
- `dc` out 1: panel D/C (0 = command, 1 = data).
- `lcd_rst_n` out 1: panel hardware reset.
- `init_done` out 1: init script complete; sticky until reset.
- `px_valid` in 1: plot request.
- `px_ready` out 1: sequencer idle and able to accept a plot.
- `px_x` in 9: column, 0–239.
- `px_y` in 9: row, 0–319.
- `px_color` in 16: RGB565.

## Operation
- **Reset values:**
  - `spi_valid`=0, `spi_data`=0, `spi_mode`=WRITE_8.
  - `dc`=0, `lcd_rst_n`=0, `init_done`=0, `px_ready`=0.
  - State = RST_HOLD; ROM pointer = 0; counters = 0.
- **FSM:**
  - RST_HOLD: `lcd_rst_n`=0 for RST_MS×MS_CYCLES cycles, then → RST_WAIT.
  - RST_WAIT: `lcd_rst_n`=1 for WAKE_MS×MS_CYCLES cycles, then → INIT_FETCH.
  - INIT_FETCH: decode the ROM entry.
    - CMD → ISSUE with dc=0, WRITE_8.
    - DATA → ISSUE with dc=1, WRITE_8.
    - DELAY → DELAY for payload×MS_CYCLES cycles.
    - END → IDLE and set `init_done`.
  - Each ISSUE or DELAY completion increments the pointer and returns to INIT_FETCH.
  - IDLE: `px_ready`=1. On `px_valid & px_ready`, latch x/y/color.
    - Out of range (x≥240 or y≥320): drop the request and stay in IDLE.
    - Otherwise run the plot sequence.
  - Plot sequence, in order:
    1. 0x2A (dc=0, WRITE_8)
    2. x (dc=1, WRITE_16)
    3. x (dc=1, WRITE_16)
    4. 0x2B (dc=0, WRITE_8)
    5. y (dc=1, WRITE_16)
    6. y (dc=1, WRITE_16)
    7. 0x2C (dc=0, WRITE_8)
    8. color (dc=1, WRITE_16)
  - After step 8 → IDLE.
- **ROM entry format** (10 bits): [9:8] type (00 CMD, 01 DATA, 10 DELAY, 11 END), [7:0] payload.
- **ROM contents:**
  1. CMD 0x01
  2. DELAY 5
  3. CMD 0x11
  4. DELAY 120
  5. CMD 0x3A, DATA 0x55
  6. CMD 0x36, DATA 0x48
  7. CMD 0x29
  8. END
- The delay counter is wide enough for 255×MS_CYCLES.

## Timing
- **Issue rule:**
  - `dc`, `spi_data` and `spi_mode` update only while `spi_ready`=1 and `spi_valid`=0.
  - `spi_valid` rises at the earliest one cycle after those values change.
  - `dc` is therefore stable for the whole SPI transfer.
- **Handshake:**
  - Once asserted, `spi_valid` and its data are held until `spi_valid & spi_ready`.
  - `spi_valid` drops the next cycle.
  - The FSM then waits for `spi_ready` to go low then high again before the next issue.
  - Transfers never overlap.
- **Pixel handshake:**
  - `px_ready` is high only in IDLE and drops the cycle after acceptance.
  - Requests before `init_done` are not accepted.
  - Latency from accept to first `spi_valid` is ≤2 cycles.
- **Reset mid-operation:** all outputs return to their reset values immediately (async). The in-flight transfer is abandoned; `spi_controller` shares the reset.

## Structure
- Package `ili9341_pkg`:
  - command constants `CMD_SWRESET`, `CMD_SLPOUT`, `CMD_COLMOD`, `CMD_MADCTL`, `CMD_DISPON`, `CMD_CASET`, `CMD_PASET`, `CMD_RAMWR`;
  - ROM entry type enum;
  - `LCD_W`=240, `LCD_H`=320.
- `spi_transaction_t` comes from `spi_types.sv`.
- Sub-module `ili9341_init_rom`: combinational address → entry lookup.
- Top level is the FSM and counters.

## Test plan
- **Reset/wake:** MS_CYCLES=4. `lcd_rst_n`=0 for 40 cycles, then 1 for 480 cycles before the first `spi_valid`.
- **Init script:** using a `spi_controller` instance plus an SPI monitor, expect the byte stream 01,11,3A,55,36,48,29 with dc 0,0,0,1,0,1,0, in that order. Check the gaps: ≥20 cycles after 01 and ≥480 cycles after 11. `init_done` rises after 29 completes.
- **Plot:** x=5, y=300, color=0xF800 → 2A, 0005, 0005, 2B, 012C, 012C, 2C, F800 with correct dc. `px_ready` returns to 1 afterwards.
- **Out of range:** x=240 → accepted, no SPI activity, `px_ready` back to 1 within 2 cycles.
- **Hold/no-overlap:** stall `spi_ready`. Check `spi_valid`, `spi_data` and `dc` stay stable, and `dc` never toggles while csb is low.
- **Mid-op reset:** drop `rst` during step 5 of a plot → all outputs at reset values and the init sequence replays fully.
